ssrelay_axil_regs: RTL and testbench

//  AXI4-Lite slave (responder) holding four 32-bit control/status registers for the ssrelay IP.

---
 rtl/ssrelay_axil_regs.sv | 208 ++++++++++++++++++++
 tb/tb_ssrelay_axil_regs.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssrelay_axil_regs.sv
// ssrelay_axil_regs
//   AXI4-Lite responder with four 32-bit control/status registers for the
//   ssrelay IP. The register contents and per-register write strobes are
//   exported to the ssrelay user logic.
//
// Ports
//   ACLK, ARESETN            clock, synchronous active-low reset
//   AW*/W*/B*                write address / data / response channels
//   AR*/R*                   read address / data channels
//   AWPROT, ARPROT           accepted but ignored
//   reg_out                  {reg3, reg2, reg1, reg0}
//   reg_wr_pulse             one-cycle strobe, bit i = reg i was written
//
// Build option
//   SSRELAY_AXIL_SLVERR_EN   when defined, any address with ADDR[AW-1:4] != 0
//                            is out of range: writes are dropped and reads
//                            return zero, both with SLVERR. When undefined the
//                            upper address bits alias onto ADDR[3:2].
module ssrelay_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                             AWPROT,
    input  logic                                   AWVALID,
    output logic                                   AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                                   WVALID,
    output logic                                   WREADY,
    output logic [1:0]                             BRESP,
    output logic                                   BVALID,
    input  logic                                   BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                             ARPROT,
    input  logic                                   ARVALID,
    output logic                                   ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                             RRESP,
    output logic                                   RVALID,
    input  logic                                   RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { WR_IDLE, WR_RESP } wr_state_t;
    typedef enum logic { RD_IDLE, RD_DATA } rd_state_t;

    wr_state_t                   wr_state;
    rd_state_t                   rd_state;
    logic [NUM_REGS-1:0][DW-1:0] regs;

    // AW and W may arrive in either order; whichever comes first is parked here
    logic          aw_held;
    logic          w_held;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;

    logic          aw_hs;
    logic          w_hs;
    logic          wr_commit;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [1:0]    wr_idx;
    logic [1:0]    rd_idx;
    logic          wr_oor;
    logic          rd_oor;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    // Use the parked copy when present, otherwise the live bus value, so the
    // commit can happen on the very edge that completes the second channel.
    always_comb begin
        wr_addr   = aw_held ? aw_addr_q : AWADDR;
        wr_data   = w_held  ? w_data_q  : WDATA;
        wr_strb   = w_held  ? w_strb_q  : WSTRB;
        wr_commit = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
        wr_idx    = wr_addr[3:2];
        rd_idx    = ARADDR[3:2];
    end

`ifdef SSRELAY_AXIL_SLVERR_EN
    assign wr_oor = |wr_addr[AW-1:4];
    assign rd_oor = |ARADDR[AW-1:4];

    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, wr_addr[1:0], ARADDR[1:0]};
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, wr_addr[1:0], ARADDR[1:0],
                           wr_addr[AW-1:4], ARADDR[AW-1:4]};
`endif

    // Write channel and register file
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state     <= WR_IDLE;
            AWREADY      <= 1'b0;
            WREADY       <= 1'b0;
            BVALID       <= 1'b0;
            BRESP        <= RESP_OKAY;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            regs         <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            case (wr_state)
                WR_IDLE: begin
                    if (wr_commit) begin
                        if (!wr_oor) begin
                            for (int b = 0; b < SW; b++) begin
                                if (wr_strb[b]) begin
                                    regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                                end
                            end
                            reg_wr_pulse[wr_idx] <= 1'b1;
                            BRESP                <= RESP_OKAY;
                        end else begin
                            BRESP <= RESP_SLVERR;
                        end
                        BVALID   <= 1'b1;
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b0;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        wr_state <= WR_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_addr_q <= AWADDR;
                            aw_held   <= 1'b1;
                        end
                        if (w_hs) begin
                            w_data_q <= WDATA;
                            w_strb_q <= WSTRB;
                            w_held   <= 1'b1;
                        end
                        // Also raises the readies on the first edge out of reset
                        AWREADY <= !(aw_held || aw_hs);
                        WREADY  <= !(w_held || w_hs);
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        BVALID   <= 1'b0;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b1;
                        wr_state <= WR_IDLE;
                    end
                end
            endcase
        end
    end

    // Read channel; regs is sampled before this edge's write lands, so a
    // same-edge read of a register being written returns the old value.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rd_state <= RD_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        RDATA    <= rd_oor ? '0 : regs[rd_idx];
                        RRESP    <= rd_oor ? RESP_SLVERR : RESP_OKAY;
                        RVALID   <= 1'b1;
                        ARREADY  <= 1'b0;
                        rd_state <= RD_DATA;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (RREADY) begin
                        RVALID   <= 1'b0;
                        ARREADY  <= 1'b1;
                        rd_state <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    assign reg_out = regs;

endmodule

// File: tb/tb_ssrelay_axil_regs.sv
// Self-checking bench for ssrelay_axil_regs. Expected responses, pulses and
// read data are queued when a transaction is launched and popped when the
// DUT answers; a small register model tracks the expected contents.
module tb_ssrelay_axil_regs;
    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [5:0]   AWADDR = '0;
    logic [2:0]   AWPROT = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [5:0]   ARADDR = '0;
    logic [2:0]   ARPROT = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    ssrelay_axil_regs dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [4];
    logic [1:0]  exp_b_q [$];
    logic [3:0]  exp_p_q [$];
    logic [33:0] exp_r_q [$];

    function automatic logic [127:0] model_flat();
        return {mregs[3], mregs[2], mregs[1], mregs[0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Driver: called 1 time unit after a rising edge; returns there too.
    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [3:0] pulse, output bit ok);
        bit aw_ok = 0, w_ok = 0, aw_now, w_now;
        ok = 0; resp = 'x; pulse = 'x;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
        for (int n = 0; n < 20 && !(aw_ok && w_ok); n++) begin
            aw_now = AWVALID && AWREADY;
            w_now  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_now) begin AWVALID = 0; aw_ok = 1; end
            if (w_now)  begin WVALID = 0;  w_ok = 1;  end
        end
        AWVALID = 0; WVALID = 0;
        if (!(aw_ok && w_ok)) return;
        for (int n = 0; n < 20; n++) begin
            if (BVALID) begin ok = 1; break; end
            @(posedge ACLK); #1;
        end
        if (!ok) return;
        resp = BRESP; pulse = reg_wr_pulse;
        BREADY = 1; @(posedge ACLK); #1; BREADY = 0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output bit ok);
        bit ar_ok = 0, ar_now;
        ok = 0; d = 'x; resp = 'x;
        ARADDR = a; ARVALID = 1;
        for (int n = 0; n < 20 && !ar_ok; n++) begin
            ar_now = ARVALID && ARREADY;
            @(posedge ACLK); #1;
            if (ar_now) begin ARVALID = 0; ar_ok = 1; end
        end
        ARVALID = 0;
        if (!ar_ok) return;
        for (int n = 0; n < 20; n++) begin
            if (RVALID) begin ok = 1; break; end
            @(posedge ACLK); #1;
        end
        if (!ok) return;
        d = RDATA; resp = RRESP;
        RREADY = 1; @(posedge ACLK); #1; RREADY = 0;
    endtask

    task automatic test_reset();
        ARESETN = 0;
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        checks++;
        if ({BRESP, RRESP, RDATA, reg_wr_pulse} !== '0 || reg_out !== '0) begin
            errors++; $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h pulse=%b regs=%h want 0",
                               BRESP, RRESP, RDATA, reg_wr_pulse, reg_out);
        end
        ARESETN = 1;
        @(posedge ACLK); #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            errors++; $display("FAIL ready_after_reset got %b want 111", {AWREADY, WREADY, ARREADY});
        end
        for (int i = 0; i < 4; i++) mregs[i] = '0;
    endtask

    // Write one register, pop its expected response/pulse, compare.
    task automatic write_and_check(input string nm, input logic [5:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
        logic [1:0] r, eb; logic [3:0] p, ep; bit ok;
        do_write(a, d, s, r, p, ok);
        eb = exp_b_q.pop_front(); ep = exp_p_q.pop_front();
        checks++;
        if (!ok) begin
            errors++; $display("FAIL %s timeout waiting for B", nm);
        end else if (r !== eb || p !== ep) begin
            errors++; $display("FAIL %s got bresp=%b pulse=%b want bresp=%b pulse=%b", nm, r, p, eb, ep);
        end
    endtask

    task automatic read_and_check(input string nm, input logic [5:0] a);
        logic [31:0] d; logic [1:0] r; logic [33:0] e; bit ok;
        do_read(a, d, r, ok);
        e = exp_r_q.pop_front();
        checks++;
        if (!ok) begin
            errors++; $display("FAIL %s timeout waiting for R", nm);
        end else if ({r, d} !== e) begin
            errors++; $display("FAIL %s got rresp=%b rdata=%h want rresp=%b rdata=%h", nm, r, d, e[33:32], e[31:0]);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            exp_b_q.push_back(2'b00);
            exp_p_q.push_back(4'(1 << i));
            mregs[i] = 32'(i + 1);
            write_and_check($sformatf("basic_wr%0d", i), 6'(i * 4), 32'(i + 1), 4'hF);
        end
        for (int i = 0; i < 4; i++) begin
            exp_r_q.push_back({2'b00, mregs[i]});
            read_and_check($sformatf("basic_rd%0d", i), 6'(i * 4));
        end
        // unaligned addresses alias onto the aligned word
        exp_b_q.push_back(2'b00); exp_p_q.push_back(4'b0100);
        mregs[2] = 32'h0BAD_F00D;
        write_and_check("unaligned_wr", 6'h09, 32'h0BAD_F00D, 4'hF);
        exp_r_q.push_back({2'b00, mregs[2]});
        read_and_check("unaligned_rd", 6'h0B);
        checks++;
        if (reg_out !== model_flat()) begin
            errors++; $display("FAIL basic_regout got %h want %h", reg_out, model_flat());
        end
    endtask

    task automatic test_strobe();
        exp_b_q.push_back(2'b00); exp_p_q.push_back(4'b0010);
        mregs[1] = 32'hFFFF_FFFF;
        write_and_check("strobe_fill", 6'h04, 32'hFFFF_FFFF, 4'hF);
        exp_b_q.push_back(2'b00); exp_p_q.push_back(4'b0010);
        mregs[1] = merge(mregs[1], 32'h1234_5678, 4'b0101);
        write_and_check("strobe_0101", 6'h04, 32'h1234_5678, 4'b0101);
        checks++;
        if (reg_out[63:32] !== 32'hFF34_FF78) begin
            errors++; $display("FAIL strobe_value got %h want ff34ff78", reg_out[63:32]);
        end
        // empty strobe: still pulses and answers OKAY, no byte changes
        exp_b_q.push_back(2'b00); exp_p_q.push_back(4'b0010);
        write_and_check("strobe_none", 6'h04, 32'h0000_0000, 4'b0000);
        checks++;
        if (reg_out !== model_flat()) begin
            errors++; $display("FAIL strobe_none_regs got %h want %h", reg_out, model_flat());
        end
    endtask

    task automatic test_w_before_aw();
        bit bad = 0;
        WDATA = 32'hCAFE_0003; WSTRB = 4'hF; WVALID = 1;
        checks++;
        if (WREADY !== 1'b1) begin errors++; $display("FAIL wfirst_wready got %b want 1", WREADY); end
        @(posedge ACLK); #1;
        WVALID = 0;
        for (int n = 0; n < 2; n++) begin
            if (WREADY !== 1'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) bad = 1;
            @(posedge ACLK); #1;
        end
        checks++;
        if (bad || reg_out !== model_flat()) begin
            errors++; $display("FAIL wfirst_wait got wready=%b bvalid=%b awready=%b regs=%h want 0 0 1 %h",
                               WREADY, BVALID, AWREADY, reg_out, model_flat());
        end
        AWADDR = 6'h0C; AWVALID = 1;
        mregs[3] = 32'hCAFE_0003;
        exp_b_q.push_back(2'b00); exp_p_q.push_back(4'b1000);
        @(posedge ACLK); #1;
        AWVALID = 0;
        begin
            logic [1:0] eb = exp_b_q.pop_front();
            logic [3:0] ep = exp_p_q.pop_front();
            checks++;
            if (BVALID !== 1'b1 || BRESP !== eb || reg_wr_pulse !== ep || reg_out !== model_flat()) begin
                errors++; $display("FAIL wfirst_commit got bvalid=%b bresp=%b pulse=%b regs=%h want 1 %b %b %h",
                                   BVALID, BRESP, reg_wr_pulse, reg_out, eb, ep, model_flat());
            end
        end
        BREADY = 1; @(posedge ACLK); #1; BREADY = 0;
        checks++;
        if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
            errors++; $display("FAIL wfirst_retire got %b want 011", {BVALID, AWREADY, WREADY});
        end
    endtask

    task automatic test_backpressure();
        bit bad = 0;
        AWADDR = 6'h08; WDATA = 32'h5A5A_0004; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        @(posedge ACLK); #1;
        mregs[2] = 32'h5A5A_0004;
        // keep offering a second write that must not be taken
        AWADDR = 6'h00; WDATA = 32'hDEAD_BEEF;
        for (int n = 0; n < 5; n++) begin
            if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || WREADY !== 1'b0) bad = 1;
            @(posedge ACLK); #1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL bp_write_hold got bvalid=%b bresp=%b awready=%b wready=%b want 1 00 0 0",
                               BVALID, BRESP, AWREADY, WREADY);
        end
        AWVALID = 0; WVALID = 0;
        BREADY = 1; @(posedge ACLK); #1; BREADY = 0;
        checks++;
        if (reg_out !== model_flat() || BVALID !== 1'b0) begin
            errors++; $display("FAIL bp_write_regs got %h bvalid=%b want %h 0", reg_out, BVALID, model_flat());
        end

        bad = 0;
        exp_r_q.push_back({2'b00, mregs[2]});
        ARADDR = 6'h08; ARVALID = 1;
        @(posedge ACLK); #1;
        ARADDR = 6'h00;
        begin
            logic [33:0] e = exp_r_q.pop_front();
            for (int n = 0; n < 5; n++) begin
                if (RVALID !== 1'b1 || {RRESP, RDATA} !== e || ARREADY !== 1'b0) bad = 1;
                @(posedge ACLK); #1;
            end
            checks++;
            if (bad) begin
                errors++; $display("FAIL bp_read_hold got rvalid=%b rresp=%b rdata=%h arready=%b want 1 %b %h 0",
                                   RVALID, RRESP, RDATA, ARREADY, e[33:32], e[31:0]);
            end
        end
        ARVALID = 0;
        RREADY = 1; @(posedge ACLK); #1; RREADY = 0;
        checks++;
        if ({RVALID, ARREADY} !== 2'b01) begin
            errors++; $display("FAIL bp_read_retire got %b want 01", {RVALID, ARREADY});
        end
    endtask

    task automatic test_out_of_range();
`ifdef SSRELAY_AXIL_SLVERR_EN
        exp_b_q.push_back(2'b10); exp_p_q.push_back(4'b0000);
        exp_r_q.push_back({2'b10, 32'h0});
`else
        exp_b_q.push_back(2'b00); exp_p_q.push_back(4'b0001);
        mregs[0] = 32'h0000_00AA;
        exp_r_q.push_back({2'b00, 32'h0000_00AA});
`endif
        write_and_check("oor_write", 6'h10, 32'h0000_00AA, 4'hF);
        checks++;
        if (reg_out !== model_flat()) begin
            errors++; $display("FAIL oor_regs got %h want %h", reg_out, model_flat());
        end
        read_and_check("oor_read", 6'h10);
    endtask

    task automatic test_reset_mid();
        AWADDR = 6'h04; WDATA = 32'h7777_7777; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
        checks++;
        if (BVALID !== 1'b1) begin errors++; $display("FAIL rstmid_bvalid got %b want 1", BVALID); end
        ARESETN = 0;
        @(posedge ACLK); #1;
        ARESETN = 1;
        for (int i = 0; i < 4; i++) mregs[i] = '0;
        checks++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b0 || reg_out !== model_flat()) begin
            errors++; $display("FAIL rstmid_state got bvalid=%b awready=%b regs=%h want 0 0 0", BVALID, AWREADY, reg_out);
        end
        @(posedge ACLK); #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID} !== 4'b1110) begin
            errors++; $display("FAIL rstmid_release got %b want 1110", {AWREADY, WREADY, ARREADY, BVALID});
        end
        // normal traffic resumes
        exp_b_q.push_back(2'b00); exp_p_q.push_back(4'b0001);
        mregs[0] = 32'h0000_1234;
        write_and_check("rstmid_wr", 6'h00, 32'h0000_1234, 4'hF);
        exp_r_q.push_back({2'b00, mregs[0]});
        read_and_check("rstmid_rd", 6'h00);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_w_before_aw();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
